// File: rtl/apb_master_arbiter_pkg.sv
// Shared definitions for the two-requester APB master: FSM state encoding
// and the fixed requester/data geometry.
package apb_master_arbiter_pkg;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/apb_rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// vector; the preference pointer moves to the other requester once the
// current owner's transfer has been answered.
module apb_rr_arbiter2
    import apb_master_arbiter_pkg::*;
(
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic             owner,
    output logic             grant_valid,
    output logic             grant_idx
);

    logic ptr_reg;

    // Pick the single requester, or the preferred one when both ask.
    always_comb begin
        grant_valid = |req;
        grant_idx   = (req == 2'b11) ? ptr_reg : req[1];
    end

    // Preference pointer: requester 0 after reset, then alternates per owner.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr_reg <= 1'b0;
        end else if (advance) begin
            ptr_reg <= ~owner;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two valid/ack requesters. Arbitrates round-robin,
// decodes the address onto P_NUM slave selects, runs SETUP/ACCESS, and
// returns read data / error through a one-cycle response pulse. ACCESS is
// abandoned with an error if the slave stalls for P_TIMEOUT cycles.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int P_NUM      = 4,
    parameter int P_SLV_BITS = 10,
    parameter int P_TIMEOUT  = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [N_REQ-1:0]        REQ_VALID,
    input  logic [N_REQ-1:0]        REQ_WRITE,
    input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [N_REQ*DATA_W-1:0] REQ_WDATA,
    output logic [N_REQ-1:0]        REQ_ACK,
    output logic [N_REQ-1:0]        RSP_VALID,
    output logic [DATA_W-1:0]       RSP_RDATA,
    output logic                    RSP_ERR,
    output logic [P_NUM-1:0]        PSEL,
    output logic [ADDR_W-1:0]       PADDR,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_W-1:0]       PWDATA,
    input  logic [P_NUM*DATA_W-1:0] PRDATA,
    input  logic [P_NUM-1:0]        PREADY,
    input  logic [P_NUM-1:0]        PSLVERR
);

    localparam int IDX_W  = (P_NUM > 1) ? $clog2(P_NUM) : 1;
    localparam int TMO_W  = $clog2(P_TIMEOUT);
    localparam int HI_LSB = P_SLV_BITS + IDX_W;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT - 1);

    // Unpacked views of the flattened buses
    logic [ADDR_W-1:0] req_addr_arr  [N_REQ];
    logic [DATA_W-1:0] req_wdata_arr [N_REQ];
    logic [DATA_W-1:0] prdata_arr    [P_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_addr_arr[gi]  = REQ_ADDR[gi*ADDR_W +: ADDR_W];
            assign req_wdata_arr[gi] = REQ_WDATA[gi*DATA_W +: DATA_W];
        end
        for (gi = 0; gi < P_NUM; gi++) begin : g_slv
            assign prdata_arr[gi] = PRDATA[gi*DATA_W +: DATA_W];
        end
    endgenerate

    state_t            state_reg;
    logic              owner_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              miss_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [N_REQ-1:0]  req_ack_reg;
    logic [N_REQ-1:0]  rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;
    logic [P_NUM-1:0]  psel_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic              penable_reg;
    logic              pwrite_reg;
    logic [DATA_W-1:0] pwdata_reg;

    logic              grant_valid;
    logic              grant_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_hit;
    logic [P_NUM-1:0]  sel_onehot;

    apb_rr_arbiter2 u_arb (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req         (REQ_VALID),
        .advance     (state_reg == ST_RESP),
        .owner       (owner_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Address decode of the granted requester's command
    always_comb begin
        sel_addr   = req_addr_arr[grant_idx];
        sel_idx    = sel_addr[P_SLV_BITS +: IDX_W];
        sel_hit    = ((sel_addr >> HI_LSB) == '0) && (32'(sel_idx) < 32'(P_NUM));
        sel_onehot = {{(P_NUM-1){1'b0}}, 1'b1} << sel_idx;
    end

    // Transfer FSM with all bus and response outputs registered. A decode
    // miss walks SETUP/ACCESS with no select asserted so its response has
    // the same cadence as a zero-wait transfer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= 1'b0;
            idx_reg       <= '0;
            miss_reg      <= 1'b0;
            tmo_cnt_reg   <= '0;
            req_ack_reg   <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            psel_reg      <= '0;
            paddr_reg     <= '0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
        end else begin
            req_ack_reg   <= '0;
            rsp_valid_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_reg              <= grant_idx;
                        req_ack_reg[grant_idx] <= 1'b1;
                        paddr_reg              <= sel_addr;
                        pwrite_reg             <= REQ_WRITE[grant_idx];
                        pwdata_reg             <= req_wdata_arr[grant_idx];
                        idx_reg                <= sel_idx;
                        miss_reg               <= ~sel_hit;
                        psel_reg               <= sel_hit ? sel_onehot : '0;
                        state_reg              <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_reg <= ~miss_reg;
                    tmo_cnt_reg <= '0;
                    state_reg   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (miss_reg || PREADY[idx_reg] || (tmo_cnt_reg == TMO_LAST)) begin
                        psel_reg                 <= '0;
                        penable_reg              <= 1'b0;
                        rsp_valid_reg[owner_reg] <= 1'b1;
                        state_reg                <= ST_RESP;
                        if (!miss_reg && PREADY[idx_reg]) begin
                            rsp_rdata_reg <= pwrite_reg ? '0 : prdata_arr[idx_reg];
                            rsp_err_reg   <= PSLVERR[idx_reg];
                        end else begin
                            rsp_rdata_reg <= '0;
                            rsp_err_reg   <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ_ACK   = req_ack_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_RDATA = rsp_rdata_reg;
    assign RSP_ERR   = rsp_err_reg;
    assign PSEL      = psel_reg;
    assign PADDR     = paddr_reg;
    assign PENABLE   = penable_reg;
    assign PWRITE    = pwrite_reg;
    assign PWDATA    = pwdata_reg;

endmodule
